// File: rtl/nibble_arbiter_pkg.sv
// nibble_arbiter_pkg
// Shared definitions for the nibble arbiter:
//   state_t          - arbiter FSM state encoding
//   HOLD_CYCLES_MIN  - smallest legal grant hold length after load
package nibble_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam int HOLD_CYCLES_MIN = 1;

endpackage

// File: rtl/lib_reg.sv
// lib_reg
// Generic enable register with reset and clear, both synchronous.
// Ports:
//   clock  - clock, rising edge
//   reset  - synchronous reset to zero (highest priority)
//   clear  - synchronous clear to zero
//   en     - load enable
//   d      - data in
//   q      - registered data out
module lib_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_reg;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      q_reg <= '0;
    end else if (en) begin
      q_reg <= d;
    end
  end

  assign q = q_reg;

endmodule

// File: rtl/nibble_arbiter_rr_picker.sv
// rr_picker
// Combinational round-robin selector: returns the first set request bit at
// or above pointer, wrapping modulo N.
// Ports:
//   req     - request vector
//   pointer - index with highest priority
//   index   - selected requester (0 when valid is low)
//   valid   - at least one request is set
module rr_picker
  import nibble_arbiter_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] pointer,
  output logic [$clog2(N)-1:0] index,
  output logic                 valid
);

  localparam int IW  = $clog2(N);
  localparam int IW1 = IW + 1;

  // rot[k] is the request at distance k from the pointer; rot_idx[k] is its
  // absolute index. One extra bit on the sum avoids overflow before the wrap.
  logic [N-1:0]  rot;
  logic [IW-1:0] rot_idx [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_rot
    logic [IW:0]   sum;
    logic [IW-1:0] idx;
    assign sum         = {1'b0, pointer} + IW1'(gi);
    assign idx         = (sum >= IW1'(N)) ? IW'(sum - IW1'(N)) : IW'(sum);
    assign rot[gi]     = req[idx];
    assign rot_idx[gi] = idx;
  end

  // Scan from farthest to nearest so the nearest set bit wins.
  always_comb begin
    index = '0;
    valid = |req;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot[k]) begin
        index = rot_idx[k];
      end
    end
  end

endmodule

// File: rtl/nibble_arbiter.sv
// nibble_arbiter
// Round-robin arbiter granting one requester at a time ownership of a shared
// WIDTH-bit register. A grant runs LOAD -> HOLD (HOLD_CYCLES cycles) -> DONE,
// followed by one IDLE cycle before the next arbitration.
// Optional build macro NIBBLE_ARBITER_STATS_EN adds a saturating 16-bit count
// of completed transactions on port grant_count.
// Ports:
//   clock       - clock, rising edge
//   reset       - synchronous active-high reset
//   req         - per-requester request level
//   req_data    - per-requester data, requester i at [i*WIDTH +: WIDTH]
//   gnt         - one-hot grant to the current owner, zero when idle
//   done        - one-cycle completion pulse to the owner
//   shared_q    - shared register contents
//   owner       - index of the last-granted requester
//   busy        - high whenever the FSM is not idle
//   grant_count - (stats build only) completed transaction count
module nibble_arbiter
  import nibble_arbiter_pkg::*;
#(
  parameter int REQUESTERS  = 4,
  parameter int WIDTH       = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [REQUESTERS-1:0]         req,
  input  logic [REQUESTERS*WIDTH-1:0]   req_data,
  output logic [REQUESTERS-1:0]         gnt,
  output logic [REQUESTERS-1:0]         done,
  output logic [WIDTH-1:0]              shared_q,
  output logic [$clog2(REQUESTERS)-1:0] owner,
  output logic                          busy
`ifdef NIBBLE_ARBITER_STATS_EN
  ,
  output logic [15:0]                   grant_count
`endif
);

  localparam int IW = $clog2(REQUESTERS);
  // Out-of-range hold lengths are clamped to the legal minimum.
  localparam int HOLD_EFF = (HOLD_CYCLES < HOLD_CYCLES_MIN) ? HOLD_CYCLES_MIN : HOLD_CYCLES;
  localparam int CW = (HOLD_EFF > 1) ? $clog2(HOLD_EFF) : 1;

  state_t        state_reg, state_next;
  logic [IW-1:0] owner_reg, owner_next;
  logic [IW-1:0] pointer_reg, pointer_next;
  logic [CW-1:0] count_reg, count_next;

  logic [IW-1:0]         pick_index;
  logic                  pick_valid;
  logic [REQUESTERS-1:0] owner_hot;
  logic [IW-1:0]         pointer_wrap;
  logic [WIDTH-1:0]      load_data;

  rr_picker #(.N(REQUESTERS)) u_picker (
    .req     (req),
    .pointer (pointer_reg),
    .index   (pick_index),
    .valid   (pick_valid)
  );

  for (genvar gi = 0; gi < REQUESTERS; gi++) begin : g_hot
    assign owner_hot[gi] = (owner_reg == IW'(gi));
  end

  assign pointer_wrap = (owner_reg == IW'(REQUESTERS - 1)) ? '0 : owner_reg + IW'(1);

  always_comb begin
    load_data = '0;
    for (int i = 0; i < REQUESTERS; i++) begin
      if (owner_reg == IW'(i)) begin
        load_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= ST_IDLE;
      owner_reg   <= '0;
      pointer_reg <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      owner_reg   <= owner_next;
      pointer_reg <= pointer_next;
      count_reg   <= count_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    owner_next   = owner_reg;
    pointer_next = pointer_reg;
    count_next   = count_reg;
    case (state_reg)
      ST_IDLE: begin
        if (pick_valid) begin
          owner_next = pick_index;
          state_next = ST_LOAD;
        end
      end
      ST_LOAD: begin
        count_next = CW'(HOLD_EFF - 1);
        state_next = ST_HOLD;
      end
      ST_HOLD: begin
        if (count_reg == '0) begin
          state_next = ST_DONE;
        end else begin
          count_next = count_reg - CW'(1);
        end
      end
      ST_DONE: begin
        pointer_next = pointer_wrap;
        state_next   = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // The library register's own reset is unused; clearing through the
  // synchronous clear input keeps the whole block synchronously reset.
  lib_reg #(.WIDTH(WIDTH)) u_shared (
    .clock (clock),
    .reset (1'b0),
    .clear (reset),
    .en    (state_reg == ST_LOAD),
    .d     (load_data),
    .q     (shared_q)
  );

  assign busy  = (state_reg != ST_IDLE);
  assign gnt   = busy ? owner_hot : '0;
  assign done  = (state_reg == ST_DONE) ? owner_hot : '0;
  assign owner = owner_reg;

`ifdef NIBBLE_ARBITER_STATS_EN
  logic [15:0] grant_count_reg;

  always_ff @(posedge clock) begin
    if (reset) begin
      grant_count_reg <= '0;
    end else if (state_reg == ST_DONE && grant_count_reg != 16'hFFFF) begin
      grant_count_reg <= grant_count_reg + 16'd1;
    end
  end

  assign grant_count = grant_count_reg;
`endif

endmodule

// File: tb/tb_nibble_arbiter.sv
// tb_nibble_arbiter
// Randomized and directed stimulus for nibble_arbiter (4 requesters, 4-bit
// data, hold of 2). A transaction-level model predicts each grant (owner,
// grant cycle, done cycle, captured data) into a queue; a monitor on the
// falling edge pops and compares whenever a grant starts or done pulses.
module tb_nibble_arbiter;

  localparam int N = 4;
  localparam int W = 4;
  localparam int H = 2;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [W-1:0]   shared_q;
  logic [1:0]     owner;
  logic           busy;
`ifdef NIBBLE_ARBITER_STATS_EN
  logic [15:0]    grant_count;
`endif

  nibble_arbiter #(.REQUESTERS(N), .WIDTH(W), .HOLD_CYCLES(H)) dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .req_data (req_data),
    .gnt      (gnt),
    .done     (done),
    .shared_q (shared_q),
    .owner    (owner),
    .busy     (busy)
`ifdef NIBBLE_ARBITER_STATS_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         own;
    logic [W-1:0] data;
    int         gnt_cyc;
    int         done_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   next_free = 0;
  int   m_ptr = 0;
  int   pend_valid = 0;
  int   pend_cyc = 0;
  int   pend_own = 0;
  int   stat_cnt = 0;
  bit   mon_en = 0;
  logic [N-1:0] gnt_prev = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end else begin
      $display("ok   %s cycle=%0d value=%0h", name, cyc, act);
    end
  endtask

  // Advance one cycle, drive inputs for the new cycle and update the model.
  task automatic tick(input logic [N-1:0] r, input logic [N*W-1:0] d, input logic rst);
    @(posedge clock);
    #1;
    cyc++;
    req      = r;
    req_data = d;
    reset    = rst;
    if (rst) begin
      exp_q.delete();
      pend_valid = 0;
      next_free  = cyc + 1;
      m_ptr      = 0;
      stat_cnt   = 0;
      return;
    end
    // The owner's data is taken during the cycle after arbitration.
    if (pend_valid != 0 && cyc == pend_cyc + 1) begin
      exp_t e;
      e.own      = pend_own;
      e.data     = d[pend_own*W +: W];
      e.gnt_cyc  = cyc;
      e.done_cyc = cyc + H + 1;
      exp_q.push_back(e);
      pend_valid = 0;
    end
    if (cyc >= next_free && r != '0) begin
      for (int k = 0; k < N; k++) begin
        if (r[(m_ptr + k) % N]) begin
          pend_own = (m_ptr + k) % N;
          break;
        end
      end
      pend_valid = 1;
      pend_cyc   = cyc;
      next_free  = cyc + H + 3;
      m_ptr      = (pend_own + 1) % N;
    end
  endtask

  always @(negedge clock) begin
    if (mon_en) begin
      total++;
      if ((done & ~gnt) != '0 || $countones(gnt) > 1 || busy !== (gnt != '0)) begin
        bad++;
        $display("FAIL invariant cycle=%0d actual gnt=%b done=%b busy=%b", cyc, gnt, done, busy);
      end
      if (gnt != '0 && gnt_prev == '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 32'h0);
        end else begin
          chk("gnt_vec", 32'(gnt), 32'(1) << exp_q[0].own);
          chk("gnt_cycle", 32'(cyc), 32'(exp_q[0].gnt_cyc));
          chk("owner", 32'(owner), 32'(exp_q[0].own));
        end
      end
      if (done != '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(done), 32'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("done_vec", 32'(done), 32'(1) << e.own);
          chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
          chk("shared_q", 32'(shared_q), 32'(e.data));
          stat_cnt++;
        end
      end
      gnt_prev = gnt;
    end
  end

  task automatic drain();
    for (int i = 0; i < 30 && (exp_q.size() != 0 || pend_valid != 0); i++) begin
      tick('0, $urandom, 1'b0);
    end
    tick('0, '0, 1'b0);
    chk("drain", 32'(exp_q.size() + pend_valid), 32'h0);
  endtask

  initial begin
    logic [N-1:0] r;
    logic [N-1:0] cur;

    // Reset and its state.
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b1);
    @(negedge clock);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_shared_q", 32'(shared_q), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    mon_en = 1;

    // Single request from requester 2.
    tick(4'b0100, 16'h0A00, 1'b0);
    for (int i = 0; i < 7; i++) tick('0, 16'h0A00, 1'b0);
    drain();

    // Wrap: pointer now 3, requesters 0 and 1 both pending.
    for (int i = 0; i < 11; i++) tick(4'b0011, 16'h0087, 1'b0);
    drain();

    // All requesting: five grants rotating from the pointer.
    for (int i = 0; i < 25; i++) tick(4'b1111, $urandom, 1'b0);
    drain();

    // Requester 1 drops and data changes during HOLD.
    tick(4'b0010, 16'h00C0, 1'b0);
    tick(4'b0010, 16'h00C0, 1'b0);
    tick(4'b0000, 16'h00F0, 1'b0);
    tick(4'b0000, 16'h0030, 1'b0);
    drain();

    // Random traffic.
    cur = '0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cur = N'($urandom);
      r = cur;
      tick(r, $urandom, 1'b0);
    end
    drain();

    // Reset during HOLD: no done pulse, outputs cleared next cycle.
    tick(4'b0001, 16'h0005, 1'b0);
    tick(4'b0000, 16'h0005, 1'b0);
    tick(4'b0000, 16'h0005, 1'b0);
    tick(4'b0000, 16'h0005, 1'b1);
    tick(4'b0000, 16'h0005, 1'b0);
    @(negedge clock);
    chk("hold_rst_gnt", 32'(gnt), 32'h0);
    chk("hold_rst_busy", 32'(busy), 32'h0);
    chk("hold_rst_shared_q", 32'(shared_q), 32'h0);
    chk("hold_rst_owner", 32'(owner), 32'h0);
    for (int i = 0; i < 8; i++) tick('0, '0, 1'b0);

    // Fresh traffic after reset, then a stats check when built in.
    for (int i = 0; i < 15; i++) tick(4'b1010, $urandom, 1'b0);
    drain();
`ifdef NIBBLE_ARBITER_STATS_EN
    chk("grant_count", 32'(grant_count), 32'(stat_cnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_arbiter.md
NIBBLE_ARBITER -- requirements
Module: nibble_arbiter

Interface
REQ-001 Parameter REQUESTERS, default 4: number of requesters sharing the register; legal range 2..8.
REQ-002 Parameter WIDTH, default 4: data width per requester and of the shared register.
REQ-003 Parameter HOLD_CYCLES, default 2: cycles the grant is held after load; legal minimum 1.
REQ-004 Port clock  input  1: single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1: synchronous, active-high reset.
REQ-006 Port req  input  REQUESTERS: request line per requester, level-sensitive.
REQ-007 Port req_data  input  REQUESTERS*WIDTH: requester i drives bits [i*WIDTH +: WIDTH].
REQ-008 Port gnt  output  REQUESTERS: one-hot grant to the current owner, zero when idle.
REQ-009 Port done  output  REQUESTERS: one-cycle completion pulse to the owner.
REQ-010 Port shared_q  output  WIDTH: contents of the shared register.
REQ-011 Port owner  output  $clog2(REQUESTERS): index of the last-granted requester.
REQ-012 Port busy  output  1: high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, LOAD, HOLD, DONE; the encoding is defined in the package.
REQ-014 IDLE with req nonzero: select the first set bit at or above the priority pointer, wrapping modulo REQUESTERS; latch it into owner; go to LOAD.
REQ-015 IDLE with req all zero: remain in IDLE; owner, pointer and shared_q hold.
REQ-016 LOAD: gnt[owner]=1; at the edge, shared_q <= req_data slice of owner; hold counter <= HOLD_CYCLES-1; go to HOLD.
REQ-017 HOLD: gnt[owner]=1; counter decrements each cycle; go to DONE on the edge where the counter equals 0.
REQ-018 DONE: gnt[owner]=1 and done[owner]=1 for exactly one cycle; pointer <= (owner+1) mod REQUESTERS; go to IDLE.
REQ-019 Latency: req seen in IDLE at cycle 0 -> gnt at cycle 1, shared_q valid at cycle 2, done at cycle HOLD_CYCLES+2, IDLE at cycle HOLD_CYCLES+3.
REQ-020 There is exactly one IDLE cycle between consecutive grants, even with requests pending.
REQ-021 Deassertion of req[owner] after IDLE does not abort the transaction; it runs to DONE.
REQ-022 req_data changes after the LOAD edge do not affect shared_q.
REQ-023 Fairness: with all requests held high, grants rotate 0,1,...,REQUESTERS-1,0.
REQ-024 gnt and done are never set for more than one requester; done is a subset of gnt.

Reset
REQ-025 Reset sets: state IDLE, gnt=0, done=0, busy=0, shared_q=0, owner=0, pointer=0, counter=0.
REQ-026 Reset asserted in any state, including mid-transaction, takes effect at the next edge; no done pulse is produced for the aborted transaction.

Configuration
REQ-027 Macro NIBBLE_ARBITER_STATS_EN defined: add port grant_count, output, 16 bits; it increments in each DONE cycle, saturates at 16'hFFFF and is cleared by reset.
REQ-028 Macro NIBBLE_ARBITER_STATS_EN undefined: the grant_count port and counter are absent; all other behaviour is identical.

Structure
REQ-029 Package nibble_arbiter_pkg holds the state enum typedef and the HOLD_CYCLES minimum constant.
REQ-030 Sub-module rr_picker (combinational: req, pointer -> index, valid) implements the round-robin selection.
REQ-031 shared_q is held in a library register instance with reset tied low, clear driven by reset and en driven by the LOAD state, so that reset is synchronous.

Verification
REQ-032 Single request: with req=4'b0100 and req_data=16'h0A00, gnt=4'b0100 at cycle 1, shared_q=4'hA at cycle 2, done=4'b0100 only at cycle 4 (HOLD_CYCLES=2).
REQ-033 All requesting: req=4'b1111 held -> owners 0,1,2,3,0 in order; each grant lasts 4 cycles with 1 IDLE cycle between grants.
REQ-034 Wrap: pointer=3 after granting 2, req=4'b0011 -> grant 0, then grant 1.
REQ-035 Drop and change: req[1] dropped and req_data changed during HOLD -> done[1] still pulses and shared_q keeps the value captured at LOAD.
REQ-036 Reset during HOLD -> next cycle IDLE, gnt=0, shared_q=0 and no done pulse.
REQ-037 With NIBBLE_ARBITER_STATS_EN: 3 completed transactions -> grant_count=3; a forced 16'hFFFF stays 16'hFFFF after another completed transaction.
